// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: the requester drives start/a/b,
// the adder returns busy/done and the registered sum with its carry-out.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, a, b,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell plus a carry flop, LSB-first over
// WIDTH cycles, with a one-cycle done pulse and a result held until the next done.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             s_bit;
  logic             c_next;

  // The single full-adder cell working on the current LSBs.
  assign s_bit  = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
  assign c_next = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & carry_q) | (sh_b_q[0] & carry_q);

  always_comb begin
    state_d     = state_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    res_d       = res_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SHIFT;
          sh_a_d  = bus.a;
          sh_b_d  = bus.b;
          carry_d = 1'b0;
          cnt_d   = '0;
          res_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        carry_d = c_next;
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        sh_a_d  = {1'b0, sh_a_q[WIDTH-1:1]};
        sh_b_d  = {1'b0, sh_b_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        // Publish the result on the edge that consumes the MSB.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          sum_d       = {s_bit, res_q[WIDTH-1:1]};
          carry_out_d = c_next;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      res_q       <= res_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks for serial_adder at WIDTH=8: vector table, start-hold,
// back-to-back, asynchronous reset mid-operation and a reference-model sweep.
module tb_serial_adder;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int passes;
  int overlap_cnt;
  int x_cnt;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         co;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // busy/done must never coincide and outputs must never be X once out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.busy === 1'b1 && bus.done === 1'b1) overlap_cnt++;
      if ($isunknown({bus.busy, bus.done, bus.sum, bus.carry_out})) x_cnt++;
    end
  end

  // One transaction; gap idle cycles first (0 = launch from the DONE cycle).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_sum, input logic exp_co, input int gap);
    int  nb;
    bit  got;
    repeat (gap) @(posedge clk);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom;
    nb = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.done === 1'b1) got = 1'b1;
      else begin
        if (bus.busy === 1'b1) nb++;
        @(posedge clk); #1;
      end
    end
    $display("op a=%02h b=%02h -> sum=%02h co=%0b busy_cycles=%0d done=%0b",
             a, b, bus.sum, bus.carry_out, nb, got);
    check("done_seen", 32'(got), 32'd1);
    check("busy_cycles", 32'(nb), 32'(W));
    check("sum", 32'(bus.sum), 32'(exp_sum));
    check("carry_out", 32'(bus.carry_out), 32'(exp_co));
  endtask

  initial begin
    int misplaced, ndone, held_bad, k;
    bit got;
    logic [W-1:0] s1, s2, s3;
    logic         c1, c2, c3;
    logic [W-1:0] ra, rb;
    logic [W:0]   ref_sum;

    checks = 0; passes = 0; overlap_cnt = 0; x_cnt = 0;

    vecs[0] = '{8'h35, 8'h4A, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[4] = '{8'h10, 8'h20, 8'h30, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[6] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 8'hFF, 1'b0};

    rst_n = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_carry", 32'(bus.carry_out), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Vector table; odd entries launch back-to-back from DONE.
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].co, (i % 2 == 0) ? 2 : 0);

    // start held high across three operations; operands change mid-SHIFT.
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20;
    misplaced = 0; ndone = 0;
    s1 = '0; s2 = '0; s3 = '0; c1 = 1'b0; c2 = 1'b0; c3 = 1'b0;
    for (k = 0; k <= 26; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin bus.a = 8'hFF; bus.b = 8'hFF; end
      if (bus.done === 1'b1) ndone++;
      if ((bus.done === 1'b1) != (k == 8 || k == 17 || k == 26)) misplaced++;
      if (k == 8)  begin s1 = bus.sum; c1 = bus.carry_out; end
      if (k == 17) begin s2 = bus.sum; c2 = bus.carry_out; end
      if (k == 26) begin s3 = bus.sum; c3 = bus.carry_out; end
    end
    bus.start = 1'b0;
    $display("hold-start: dones=%0d misplaced=%0d sums=%02h/%02h/%02h", ndone, misplaced, s1, s2, s3);
    check("hold_done_count", 32'(ndone), 32'd3);
    check("hold_done_spacing", 32'(misplaced), 32'd0);
    check("hold_sum1", 32'({c1, s1}), 32'h030);
    check("hold_sum2", 32'({c2, s2}), 32'h1FE);
    check("hold_sum3", 32'({c3, s3}), 32'h1FE);

    // Back-to-back from DONE: previous result must hold until the new done.
    run_op(8'h10, 8'h20, 8'h30, 1'b0, 2);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h80; bus.b = 8'h80;
    @(posedge clk); #1;
    bus.start = 1'b0;
    held_bad = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.done === 1'b1) got = 1'b1;
      else begin
        if (bus.sum !== 8'h30 || bus.carry_out !== 1'b0) held_bad++;
        @(posedge clk); #1;
      end
    end
    $display("b2b: a=80 b=80 -> sum=%02h co=%0b held_bad=%0d", bus.sum, bus.carry_out, held_bad);
    check("b2b_done_seen", 32'(got), 32'd1);
    check("b2b_prev_held", 32'(held_bad), 32'd0);
    check("b2b_sum", 32'({bus.carry_out, bus.sum}), 32'h100);

    // Asynchronous reset mid-SHIFT, between clock edges.
    run_op(8'hC3, 8'h5A, 8'h1D, 1'b1, 1);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    $display("async reset: busy=%0b done=%0b sum=%02h co=%0b", bus.busy, bus.done, bus.sum, bus.carry_out);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_sum", 32'(bus.sum), 32'd0);
    check("arst_carry", 32'(bus.carry_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    check("arst_abandoned", 32'(ndone), 32'd0);
    run_op(8'h35, 8'h4A, 8'h7F, 1'b0, 0);

    // Reference-model sweep.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ref_sum = {1'b0, ra} + {1'b0, rb};
      run_op(ra, rb, ref_sum[W-1:0], ref_sum[W], i % 3);
    end

    check("busy_done_overlap", 32'(overlap_cnt), 32'd0);
    check("x_on_outputs", 32'(x_cnt), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
